// File: rtl/reg_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// reg_cmd_ctrl
//
// Command initiator between a UART RX/TX pair and a register file.
// Parses byte frames from the receiver:
//   write : WR_CMD, addr, data  -> one-cycle WrEN with Address/WrData
//   read  : RD_CMD, addr        -> one-cycle RdEN, waits for RdData_VLD,
//                                  forwards RdData to the transmitter
// Malformed or unexpected bytes, and reads that never return, raise a
// one-cycle CMD_ERR pulse.
//
// Ports:
//   clk         in   system clock, rising edge
//   RST         in   asynchronous reset, active-high
//   RX_P_DATA   in   received byte
//   RX_D_VLD    in   one-cycle strobe, RX_P_DATA valid
//   WrEN        out  register-file write strobe
//   RdEN        out  register-file read strobe
//   Address     out  register-file address
//   WrData      out  register-file write data
//   RdData      in   register-file read data
//   RdData_VLD  in   register-file read-data valid
//   TX_P_DATA   out  byte to UART transmitter
//   TX_D_VLD    out  one-cycle strobe to transmitter
//   TX_BUSY     in   transmitter busy, no new byte accepted
//   CMD_ERR     out  one-cycle error pulse
//
// Handshake: RX_D_VLD and RdData_VLD are single-cycle strobes with no
// backpressure; a byte offered while the FSM cannot use it is dropped and
// flagged. TX_D_VLD is issued only on an edge where TX_BUSY is sampled low.
// -----------------------------------------------------------------------------
module reg_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEN,
    output logic                  RdEN,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_EXEC = 3'd3,
        RD_ADDR = 3'd4,
        RD_EXEC = 3'd5,
        RD_WAIT = 3'd6,
        TX_SEND = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
    logic [DATA_WIDTH-1:0] txdata_q, txdata_d;
    logic                  wren_q, wren_d;
    logic                  rden_q, rden_d;
    logic                  txvld_q, txvld_d;
    logic                  err_q, err_d;

    // Address byte is rejected if any bit above the address field is set.
    logic addr_hi_bad;
    assign addr_hi_bad = |(RX_P_DATA >> ADDR_WIDTH);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        txdata_d = txdata_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        txvld_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD)      state_d = WR_ADDR;
                    else if (RX_P_DATA == RD_CMD) state_d = RD_ADDR;
                    else                          err_d   = 1'b1;
                end
            end

            WR_ADDR, RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_hi_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                        if (state_q == WR_ADDR) begin
                            state_d = WR_DATA;
                        end else begin
                            rden_d  = 1'b1;
                            state_d = RD_EXEC;
                        end
                    end
                end
            end

            WR_DATA: begin
                if (RX_D_VLD) begin
                    wrdata_d = RX_P_DATA;
                    wren_d   = 1'b1;
                    state_d  = WR_EXEC;
                end
            end

            WR_EXEC: begin
                err_d   = RX_D_VLD;
                state_d = IDLE;
            end

            RD_EXEC: begin
                err_d   = RX_D_VLD;
                cnt_d   = '0;
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                err_d = RX_D_VLD;
                if (RdData_VLD) begin
                    // The edge that captures the read data is also the first
                    // chance to hand it to an idle transmitter, so the strobe
                    // is issued here when possible; TX_SEND then only retires.
                    txdata_d = RdData;
                    txvld_d  = ~TX_BUSY;
                    state_d  = TX_SEND;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            TX_SEND: begin
                err_d = RX_D_VLD;
                if (txvld_q) begin
                    state_d = IDLE;
                end else if (!TX_BUSY) begin
                    txvld_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            txdata_q <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txvld_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            txdata_q <= txdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txvld_q  <= txvld_d;
            err_q    <= err_d;
        end
    end

    assign WrEN      = wren_q;
    assign RdEN      = rden_q;
    assign Address   = addr_q;
    assign WrData    = wrdata_q;
    assign TX_P_DATA = txdata_q;
    assign TX_D_VLD  = txvld_q;
    assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
module tb_reg_cmd_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       WrEN;
  logic       RdEN;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_VLD;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY;
  logic       CMD_ERR;

  int total = 0;
  int bad   = 0;

  // pulse monitors
  int         wr_n = 0;
  int         rd_n = 0;
  int         tx_n = 0;
  int         err_n = 0;
  logic [7:0] last_tx = 8'h00;

  // responder control
  logic       resp_en;
  logic [7:0] mem [16];

  reg_cmd_ctrl dut (
    .clk        (clk),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .WrEN       (WrEN),
    .RdEN       (RdEN),
    .Address    (Address),
    .WrData     (WrData),
    .RdData     (RdData),
    .RdData_VLD (RdData_VLD),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .TX_BUSY    (TX_BUSY),
    .CMD_ERR    (CMD_ERR)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // register-file responder: data valid one cycle after RdEN is sampled
  always @(posedge clk) begin
    if (RST) begin
      RdData_VLD <= 1'b0;
      RdData     <= 8'h00;
    end else begin
      RdData_VLD <= resp_en & RdEN;
      RdData     <= mem[Address];
      if (WrEN) mem[Address] <= WrData;
    end
  end

  // monitors and the overlap invariant, sampled mid-cycle
  always @(negedge clk) begin
    total++;
    assert (!(WrEN && RdEN)) else begin
      bad++;
      $error("FAIL wr_rd_overlap observed=%0b%0b expected=not both", WrEN, RdEN);
    end
    if (WrEN) wr_n++;
    if (RdEN) rd_n++;
    if (CMD_ERR) err_n++;
    if (TX_D_VLD) begin
      tx_n++;
      last_tx = TX_P_DATA;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int w0, r0, t0, e0;

  initial begin
    RST       = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    TX_BUSY   = 1'b0;
    resp_en   = 1'b1;
    tick();
    tick();
    chk("rst_wren", {31'd0, WrEN}, 0);
    chk("rst_rden", {31'd0, RdEN}, 0);
    chk("rst_addr", {28'd0, Address}, 0);
    chk("rst_wrdata", {24'd0, WrData}, 0);
    chk("rst_txdata", {24'd0, TX_P_DATA}, 0);
    chk("rst_txvld", {31'd0, TX_D_VLD}, 0);
    chk("rst_err", {31'd0, CMD_ERR}, 0);
    RST = 1'b0;
    tick();

    // write AA,05,3C
    send_byte(8'hAA);
    send_byte(8'h05);
    chk("wr1_addr_early", {28'd0, Address}, 5);
    send_byte(8'h3C);
    chk("wr1_wren", {31'd0, WrEN}, 1);
    chk("wr1_addr", {28'd0, Address}, 5);
    chk("wr1_data", {24'd0, WrData}, 8'h3C);
    chk("wr1_rden", {31'd0, RdEN}, 0);
    tick();
    chk("wr1_wren_off", {31'd0, WrEN}, 0);
    chk("wr1_err", {31'd0, CMD_ERR}, 0);

    // read BB,05, transmitter idle
    send_byte(8'hBB);
    send_byte(8'h05);
    chk("rd1_rden", {31'd0, RdEN}, 1);
    chk("rd1_addr", {28'd0, Address}, 5);
    tick();
    chk("rd1_rden_off", {31'd0, RdEN}, 0);
    chk("rd1_txvld_c2", {31'd0, TX_D_VLD}, 0);
    tick();
    chk("rd1_txvld_c3", {31'd0, TX_D_VLD}, 1);
    chk("rd1_txdata", {24'd0, TX_P_DATA}, 8'h3C);
    tick();
    chk("rd1_txvld_off", {31'd0, TX_D_VLD}, 0);
    chk("rd1_err", {31'd0, CMD_ERR}, 0);

    // read with transmitter busy for 20 cycles
    t0 = tx_n;
    TX_BUSY = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h05);
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("busy_txvld", {31'd0, TX_D_VLD}, 0);
      chk("busy_txdata", {24'd0, TX_P_DATA}, 8'h3C);
    end
    TX_BUSY = 1'b0;
    tick();
    chk("busy_txvld_rel", {31'd0, TX_D_VLD}, 1);
    chk("busy_txdata_rel", {24'd0, TX_P_DATA}, 8'h3C);
    tick();
    chk("busy_txvld_off", {31'd0, TX_D_VLD}, 0);
    chk("busy_tx_count", tx_n - t0, 1);

    // error: bad opcode 55
    w0 = wr_n; r0 = rd_n;
    send_byte(8'h55);
    chk("op55_err", {31'd0, CMD_ERR}, 1);
    tick();
    chk("op55_err_off", {31'd0, CMD_ERR}, 0);

    // error: write address byte 15
    send_byte(8'hAA);
    send_byte(8'h15);
    chk("addr15_err", {31'd0, CMD_ERR}, 1);
    chk("addr15_addr_kept", {28'd0, Address}, 5);
    tick();
    chk("addr15_err_off", {31'd0, CMD_ERR}, 0);
    chk("err_no_strobes", (wr_n - w0) + (rd_n - r0), 0);

    // error: byte during TX_SEND
    TX_BUSY = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h05);
    tick();
    tick();
    w0 = wr_n; r0 = rd_n;
    send_byte(8'h99);
    chk("txsend_err", {31'd0, CMD_ERR}, 1);
    chk("txsend_txvld", {31'd0, TX_D_VLD}, 0);
    tick();
    chk("txsend_err_off", {31'd0, CMD_ERR}, 0);
    TX_BUSY = 1'b0;
    tick();
    chk("txsend_still_sends", {31'd0, TX_D_VLD}, 1);
    tick();
    chk("txsend_no_strobes", (wr_n - w0) + (rd_n - r0), 0);

    // error: read timeout, no RdData_VLD
    resp_en = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h05);
    e0 = err_n;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("to_wait_noerr", {31'd0, CMD_ERR}, 0);
    end
    tick();
    chk("to_err", {31'd0, CMD_ERR}, 1);
    chk("to_txdata_kept", {24'd0, TX_P_DATA}, 8'h3C);
    tick();
    chk("to_err_off", {31'd0, CMD_ERR}, 0);
    chk("to_err_count", err_n - e0, 1);
    resp_en = 1'b1;

    // recovery write AA,02,7E
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h7E);
    chk("rec_wren", {31'd0, WrEN}, 1);
    chk("rec_addr", {28'd0, Address}, 2);
    chk("rec_data", {24'd0, WrData}, 8'h7E);
    tick();

    // back-to-back AA,00,11 then BB,00
    w0 = wr_n; r0 = rd_n; t0 = tx_n; e0 = err_n;
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h11);
    tick();
    send_byte(8'hBB);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_wr_count", wr_n - w0, 1);
    chk("b2b_rd_count", rd_n - r0, 1);
    chk("b2b_tx_count", tx_n - t0, 1);
    chk("b2b_tx_data", {24'd0, last_tx}, 8'h11);
    chk("b2b_err_count", err_n - e0, 0);

    // reset between address and data bytes
    w0 = wr_n;
    send_byte(8'hAA);
    send_byte(8'h03);
    RST = 1'b1;
    #1;
    chk("mid_rst_addr", {28'd0, Address}, 0);
    chk("mid_rst_wrdata", {24'd0, WrData}, 0);
    chk("mid_rst_txdata", {24'd0, TX_P_DATA}, 0);
    chk("mid_rst_wren", {31'd0, WrEN}, 0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    send_byte(8'h3C);
    chk("stray_err", {31'd0, CMD_ERR}, 1);
    chk("stray_wren", {31'd0, WrEN}, 0);
    tick();
    chk("mid_rst_no_wr", wr_n - w0, 0);
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h08);
    chk("post_rst_wren", {31'd0, WrEN}, 1);
    chk("post_rst_addr", {28'd0, Address}, 3);
    chk("post_rst_data", {24'd0, WrData}, 8'h08);
    tick();
    chk("post_rst_wren_off", {31'd0, WrEN}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
Name: reg_cmd_ctrl

Overview:
- Command initiator for the register file: parses byte frames from the UART receiver and drives register-file write/read strobes.
- Returns read data to the UART transmitter.
- Sits between the UART RX/TX pair and the register file.
- Frames: write = WR_CMD, addr, data. Read = RD_CMD, addr.

Parameters:
DATA_WIDTH, 8, width of frame bytes, WrData, RdData and TX data
ADDR_WIDTH, 4, register-file address width
WR_CMD, 8'hAA, write-frame opcode
RD_CMD, 8'hBB, read-frame opcode
TIMEOUT, 16, max cycles in RD_WAIT before abort (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous reset, active-high
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
WrEN  out  1  register-file write strobe
RdEN  out  1  register-file read strobe
Address  out  ADDR_WIDTH  register-file address
WrData  out  DATA_WIDTH  register-file write data
RdData  in  DATA_WIDTH  register-file read data
RdData_VLD  in  1  register-file read-data valid
TX_P_DATA  out  DATA_WIDTH  byte to UART transmitter
TX_D_VLD  out  1  one-cycle strobe to transmitter
TX_BUSY  in  1  transmitter busy, no new byte accepted
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- All outputs are registered. RST high forces state IDLE, timeout counter 0, and every output to 0 immediately, regardless of clk. Any partial frame is discarded. The first byte after reset release is parsed as an opcode.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- IDLE, on RX_D_VLD:
  - byte == WR_CMD -> WR_ADDR.
  - byte == RD_CMD -> RD_ADDR.
  - any other byte -> CMD_ERR pulse, stay in IDLE.
- WR_ADDR / RD_ADDR, on RX_D_VLD:
  - If the byte's bits above ADDR_WIDTH are nonzero -> CMD_ERR pulse, IDLE, Address unchanged.
  - Otherwise Address <= byte[ADDR_WIDTH-1:0].
  - WR_ADDR -> WR_DATA.
  - RD_ADDR -> RD_EXEC, with RdEN set at the same edge.
- WR_DATA, on RX_D_VLD: WrData <= byte, WrEN set at the same edge -> WR_EXEC.
- WR_EXEC: WrEN high exactly one cycle, cleared at the next edge -> IDLE.
- RD_EXEC: RdEN high exactly one cycle, cleared at the next edge -> RD_WAIT. The timeout counter clears on entry.
- RD_WAIT:
  - Responder returns RdData_VLD one cycle after sampling RdEN.
  - On RdData_VLD: TX_P_DATA <= RdData -> TX_SEND.
  - Otherwise the counter increments. At TIMEOUT cycles in RD_WAIT without RdData_VLD -> CMD_ERR pulse, IDLE, TX_P_DATA unchanged.
- TX_SEND:
  - While TX_BUSY is high, wait indefinitely.
  - At the first edge with TX_BUSY low, TX_D_VLD high for exactly one cycle -> IDLE.
  - TX_P_DATA holds its value until the next successful read.
- RdData_VLD outside RD_WAIT is ignored.
- RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: byte dropped, CMD_ERR pulse, state unaffected. There is no RX buffering.
- Invariants:
  - WrEN and RdEN are never high in the same cycle.
  - Each is only ever a single-cycle pulse.
  - Address and WrData are stable while their strobe is high.
  - CMD_ERR is never high two cycles from one event.
- Latency, measured from the edge sampling the last frame byte:
  - write: WrEN high in the following cycle.
  - read: RdEN next cycle, RdData_VLD one cycle later, TX_D_VLD one cycle after that if TX_BUSY is low. The earliest TX_D_VLD is the 3rd cycle.

Test Plan:
- Write frame AA,05,3C, one byte per RX_D_VLD strobe -> WrEN high one cycle with Address=5, WrData=3C, RdEN=0. Then IDLE, no CMD_ERR.
- Read frame BB,05, responder returning 3C one cycle after RdEN, TX_BUSY=0 -> RdEN one cycle with Address=5. TX_D_VLD one cycle with TX_P_DATA=3C, 3 cycles after the address byte.
- Same read with TX_BUSY high for 20 cycles after RdData_VLD -> TX_D_VLD stays 0 throughout. It pulses once, on the first cycle after BUSY falls; TX_P_DATA=3C throughout.
- Error frames, each checked for CMD_ERR single-cycle pulse, no WrEN/RdEN, then IDLE:
  - opcode 55
  - write address byte 15
  - byte arriving during TX_SEND
  - read with RdData_VLD never asserted -> pulse after 16 cycles in RD_WAIT
  - A following AA,02,7E still writes 7E to address 2.
- Back-to-back frames AA,00,11 then BB,00 with responder returning 11 -> exactly one WrEN, then one RdEN, then one TX_D_VLD with 11. Invariant checked throughout: WrEN and RdEN never high together.
- RST asserted between the address and data bytes of a write frame -> all outputs 0 immediately, no WrEN. After release, the stray data byte 3C gives CMD_ERR (bad opcode). A subsequent AA,03,08 completes normally.
